fp_data: RTL and testbench
==========================

# fp_data

Fixed-point data stage that carries one signed fixed-point sample from a producer format (IN_W bits, IN_F fractional) to a consumer format (W bits, F fractional), registered, with binary-point alignment, rounding and saturation. It sits between arithmetic blocks (e.g. complex multiply-add datapaths) wherever operand formats differ. A typical use is aligning an addend's binary point to a product's binary point before accumulation.

## Interface
- IN_W, default 16: input word width, signed two's complement.
- IN_F, default 15: input fractional bits.
- W, default 16: output word width, signed two's complement.
- F, default 15: output fractional bits.
- Constraints (elaboration-time check, fatal if violated): 1 ≤ IN_W, W ≤ 64; 0 ≤ IN_F < IN_W; 0 ≤ F < W.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- din  in  IN_W  signed input sample.
- din_valid  in  1  din qualifier.
- dout  out  W  signed aligned output sample.
- dout_valid  out  1  dout qualifier.
- ovf  out  1  current dout was saturated.
- ovf_sticky  out  1  a saturation has occurred since reset or the last clear.
- ovf_clr  in  1  clears ovf_sticky.

## Operation
- SHIFT = F − IN_F, computed at elaboration.
- SHIFT ≥ 0: value = din arithmetic-shifted left by SHIFT. Exact; no rounding.
- SHIFT < 0: value = (din + 2^(−SHIFT−1)) arithmetic-shifted right by −SHIFT. This is round-half-up, i.e. toward +∞ on ties.
- Intermediate width is IN_W + |SHIFT| + 1, so the shift and rounding add never overflow.
- Saturation: if value > 2^(W−1)−1, dout = 2^(W−1)−1 and ovf = 1. If value < −2^(W−1), dout = −2^(W−1) and ovf = 1. Otherwise dout = value and ovf = 0.
- dout and ovf update only on cycles with din_valid = 1; they hold otherwise.
- dout_valid is registered from din_valid every cycle.
- ovf_sticky:
  - Set on any cycle where a valid sample saturates.
  - Cleared by ovf_clr = 1.
  - If set and clear occur in the same cycle, set wins and ovf_sticky = 1.
- No handshake or backpressure; a new sample is accepted every cycle.

## Timing
- Latency: 1 clock, from din/din_valid sampled at edge N to dout/dout_valid/ovf visible after edge N.
- Throughput: 1 sample per clock.
- Reset value of every output is 0: dout = 0, dout_valid = 0, ovf = 0, ovf_sticky = 0.
  - Reset takes effect asynchronously on assertion and holds while rst = 0.
- First sample after reset deassertion: accepted on the first rising edge with rst = 1.
- Reset asserted mid-stream: the in-flight sample is discarded and all outputs go to 0 immediately.
- ovf_sticky changes one edge after the saturating sample or ovf_clr is sampled, in the same cycle as the corresponding dout.

## Test plan
- Widen: IN_W=16, IN_F=15, W=33, F=30. din=0x4000 valid → dout=0x0_2000_0000, ovf=0 after 1 clock. din=0x8000 → dout=−2^30, ovf=0.
- Narrow with rounding, IN_W=16, IN_F=8, W=8, F=4:
  - din=24 → dout=2 (1.5 rounds up).
  - din=−24 → dout=−1 (0xFF).
  - din=23 → dout=1.
- Saturation, same formats:
  - din=0x7FFF → dout=0x7F, ovf=1, ovf_sticky=1.
  - din=0x8000 → dout=0x80, ovf=1.
  - Next in-range sample → ovf=0, ovf_sticky stays 1.
- Sticky clear: ovf_clr=1 alone → ovf_sticky=0 next edge. ovf_clr=1 together with a saturating sample → ovf_sticky=1.
- Valid gating: din_valid toggled 1,0,1 with changing din → dout holds during the invalid cycle, and dout_valid mirrors din_valid delayed by 1.
- Async reset: drop rst mid-stream between edges → all outputs 0 immediately without a clock edge. Release rst → first valid sample appears after one edge.

Source files
------------

// File: rtl/fp_data.sv
`default_nettype none
// ============================================================================
// Module   : fp_data
// Purpose  : Registered fixed-point format converter. Carries one signed
//            sample from Q(IN_W,IN_F) to Q(W,F) with binary-point alignment,
//            round-half-up on right shifts, and saturation to the output range.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous reset, active low (asserted when 0)
//   din        in   IN_W  signed input sample
//   din_valid  in   1     din qualifier
//   ovf_clr    in   1     clears ovf_sticky (a same-cycle saturation wins)
//   dout       out  W     signed aligned output sample
//   dout_valid out  1     din_valid delayed by one clock
//   ovf        out  1     current dout was saturated
//   ovf_sticky out  1     saturation seen since reset or last clear
// ============================================================================
module fp_data #(
  parameter int IN_W = 16,
  parameter int IN_F = 15,
  parameter int W    = 16,
  parameter int F    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] din,
  input  logic            din_valid,
  input  logic            ovf_clr,
  output logic [W-1:0]    dout,
  output logic            dout_valid,
  output logic            ovf,
  output logic            ovf_sticky
);

  localparam int SHIFT = F - IN_F;
  localparam int ASH   = (SHIFT < 0) ? -SHIFT : SHIFT;
  // One guard bit above the shifted range keeps the rounding add from wrapping.
  localparam int IW    = IN_W + ASH + 1;

  if (IN_W < 1 || IN_W > 64 || W < 1 || W > 64 ||
      IN_F < 0 || IN_F >= IN_W || F < 0 || F >= W) begin : g_param_check
    $fatal(1, "fp_data: illegal parameter combination");
  end

  logic signed [IW-1:0] ext;
  logic signed [IW-1:0] value;
  logic        [W-1:0]  sat_val;
  logic                 sat;

  assign ext = IW'(signed'(din));

  if (SHIFT >= 0) begin : g_left
    assign value = ext <<< ASH;
  end else begin : g_right
    localparam logic signed [IW-1:0] HALF = IW'(1) << (ASH - 1);
    // Adding half an output LSB before the arithmetic shift rounds ties up.
    assign value = (ext + HALF) >>> ASH;
  end

  if (IW > W) begin : g_sat
    localparam logic [W-1:0] MINV = W'(1) << (W - 1);
    localparam logic [W-1:0] MAXV = ~MINV;
    logic [IW-W:0] top;
    // The value fits iff every bit from the output sign bit upward agrees.
    assign top     = value[IW-1:W-1];
    assign sat     = !((&top) || !(|top));
    assign sat_val = sat ? (value[IW-1] ? MINV : MAXV) : value[W-1:0];
  end else begin : g_fit
    assign sat     = 1'b0;
    assign sat_val = W'(value);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= sat_val;
        ovf  <= sat;
      end
      if (din_valid && sat) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_data
// Purpose  : Directed self-checking bench for fp_data. Two instances: a
//            widening Q16.15 -> Q33.30 stage and a narrowing Q16.8 -> Q8.4
//            stage with rounding and saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_data;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] din_w   = '0;
  logic        vld_w   = 1'b0;
  logic        clr_w   = 1'b0;
  logic [32:0] dout_w;
  logic        dv_w, ovf_w, stk_w;

  logic [15:0] din_n   = '0;
  logic        vld_n   = 1'b0;
  logic        clr_n   = 1'b0;
  logic [7:0]  dout_n;
  logic        dv_n, ovf_n, stk_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_data #(.IN_W(16), .IN_F(15), .W(33), .F(30)) u_wide (
    .clk(clk), .rst(rst), .din(din_w), .din_valid(vld_w), .ovf_clr(clr_w),
    .dout(dout_w), .dout_valid(dv_w), .ovf(ovf_w), .ovf_sticky(stk_w)
  );

  fp_data #(.IN_W(16), .IN_F(8), .W(8), .F(4)) u_nar (
    .clk(clk), .rst(rst), .din(din_n), .din_valid(vld_n), .ovf_clr(clr_n),
    .dout(dout_n), .dout_valid(dv_n), .ovf(ovf_n), .ovf_sticky(stk_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [7:0] d, input logic o,
                       input logic s, input logic v);
    check({tag, ".dout"}, 64'(dout_n), 64'(d));
    check({tag, ".ovf"},  64'(ovf_n),  64'(o));
    check({tag, ".stk"},  64'(stk_n),  64'(s));
    check({tag, ".dv"},   64'(dv_n),   64'(v));
  endtask

  // Advance one edge; sampling and driving happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nar(input logic [15:0] d, input logic v, input logic c);
    din_n = d;
    vld_n = v;
    clr_n = c;
    step();
  endtask

  task automatic wide(input logic [15:0] d);
    din_w = d;
    vld_w = 1'b1;
    step();
    vld_w = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst.wide.dout", 64'(dout_w), 64'd0);
    check("rst.wide.dv",   64'(dv_w),   64'd0);
    chk_n("rst.nar", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Widening: exact left shift by 15
    wide(16'h4000);
    check("wide.half", 64'(dout_w), 64'h0_2000_0000);
    check("wide.half.dv", 64'(dv_w), 64'd1);
    check("wide.half.ovf", 64'(ovf_w), 64'd0);
    wide(16'h8000);
    check("wide.m1", 64'(dout_w), 64'h1_C000_0000);
    check("wide.m1.ovf", 64'(ovf_w), 64'd0);
    wide(16'h7FFF);
    check("wide.max", 64'(dout_w), 64'h0_3FFF_8000);
    check("wide.idle.stk", 64'(stk_w), 64'd0);

    // Narrowing with round-half-up
    nar(16'd24,    1'b1, 1'b0); chk_n("n.p1p5",   8'h02, 1'b0, 1'b0, 1'b1);
    nar(-16'sd24,  1'b1, 1'b0); chk_n("n.m1p5",   8'hFF, 1'b0, 1'b0, 1'b1);
    nar(16'd23,    1'b1, 1'b0); chk_n("n.p1p44",  8'h01, 1'b0, 1'b0, 1'b1);
    nar(-16'sd8,   1'b1, 1'b0); chk_n("n.m0p5",   8'h00, 1'b0, 1'b0, 1'b1);
    nar(-16'sd9,   1'b1, 1'b0); chk_n("n.m0p56",  8'hFF, 1'b0, 1'b0, 1'b1);
    nar(16'd2039,  1'b1, 1'b0); chk_n("n.maxfit", 8'h7F, 1'b0, 1'b0, 1'b1);

    // Saturation and sticky behaviour
    nar(16'h7FFF,  1'b1, 1'b0); chk_n("n.satp",   8'h7F, 1'b1, 1'b1, 1'b1);
    nar(16'h8000,  1'b1, 1'b0); chk_n("n.satn",   8'h80, 1'b1, 1'b1, 1'b1);
    nar(16'd23,    1'b1, 1'b0); chk_n("n.after",  8'h01, 1'b0, 1'b1, 1'b1);
    nar(16'd24,    1'b0, 1'b1); chk_n("n.clr",    8'h01, 1'b0, 1'b0, 1'b0);
    nar(16'd2040,  1'b1, 1'b1); chk_n("n.setwin", 8'h7F, 1'b1, 1'b1, 1'b1);
    nar(-16'sd2056, 1'b1, 1'b0); chk_n("n.minfit", 8'h80, 1'b0, 1'b1, 1'b1);
    nar(-16'sd2057, 1'b1, 1'b0); chk_n("n.minsat", 8'h80, 1'b1, 1'b1, 1'b1);
    nar(16'd23,    1'b1, 1'b1); chk_n("n.clr2",   8'h01, 1'b0, 1'b0, 1'b1);

    // Valid gating
    nar(16'd24,    1'b1, 1'b0); chk_n("g.v1",     8'h02, 1'b0, 1'b0, 1'b1);
    nar(-16'sd24,  1'b0, 1'b0); chk_n("g.v0",     8'h02, 1'b0, 1'b0, 1'b0);
    nar(16'd23,    1'b1, 1'b0); chk_n("g.v1b",    8'h01, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    din_n = 16'h7FFF;
    vld_n = 1'b1;
    din_w = 16'h4000;
    vld_w = 1'b1;
    step();
    chk_n("a.pre", 8'h7F, 1'b1, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_n("a.async", 8'h00, 1'b0, 1'b0, 1'b0);
    check("a.async.wide", 64'(dout_w), 64'd0);
    check("a.async.wdv",  64'(dv_w),   64'd0);
    step();
    chk_n("a.hold", 8'h00, 1'b0, 1'b0, 1'b0);
    rst   = 1'b1;
    vld_w = 1'b0;
    nar(16'd24, 1'b1, 1'b0); chk_n("a.first", 8'h02, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
